// File: rtl/ym_timer_bank.sv
// Bank of independent up-counting timers with load register, optional prescaler,
// one-shot/periodic modes, sticky overflow flags and a shared active-low interrupt.
module ym_timer_bank #(
  parameter int unsigned N_TIMERS  = 2,
  parameter int unsigned CNT_WIDTH = 10,
  parameter int unsigned PRE_DIV   = 16
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          TICK,
  input  logic [N_TIMERS*CNT_WIDTH-1:0] LOAD_VALUE,
  input  logic [N_TIMERS-1:0]           WR_LOAD,
  input  logic [N_TIMERS-1:0]           RUN_SET,
  input  logic [N_TIMERS-1:0]           RUN_CLR,
  input  logic [N_TIMERS-1:0]           FLAG_CLR,
  input  logic [N_TIMERS-1:0]           IRQ_EN,
  input  logic [N_TIMERS-1:0]           AUTO_RELOAD,
  input  logic [N_TIMERS-1:0]           PRESCALE_SEL,
  output logic [N_TIMERS-1:0]           FLAG,
  output logic [N_TIMERS-1:0]           OVF,
  output logic [N_TIMERS-1:0]           RUNNING,
  output logic [N_TIMERS*CNT_WIDTH-1:0] COUNT,
  output logic                          nIRQ
);

  localparam int unsigned    PRE_W   = $clog2(PRE_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRE_DIV - 1);

  logic [CNT_WIDTH-1:0] load_q [N_TIMERS];
  logic [CNT_WIDTH-1:0] cnt_q  [N_TIMERS];
  logic [PRE_W-1:0]     pre_q  [N_TIMERS];
  logic [N_TIMERS-1:0]  run_q, flag_q, ovf_q;
  logic [N_TIMERS-1:0]  cnt_en, ovf_now;

  always_comb begin
    cnt_en  = '0;
    ovf_now = '0;
    for (int unsigned i = 0; i < N_TIMERS; i++) begin
      cnt_en[i]  = run_q[i] & TICK & (~PRESCALE_SEL[i] | (pre_q[i] == PRE_MAX));
      ovf_now[i] = cnt_en[i] & (&cnt_q[i]);
    end
  end

  // Priority per channel: RUN_CLR over RUN_SET over counting; an overflow detected
  // in the same cycle as RUN_CLR still reloads, pulses OVF and sets the flag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < N_TIMERS; i++) begin
        load_q[i] <= '0;
        cnt_q[i]  <= '0;
        pre_q[i]  <= '0;
      end
      run_q  <= '0;
      flag_q <= '0;
      ovf_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < N_TIMERS; i++) begin
        if (WR_LOAD[i])
          load_q[i] <= LOAD_VALUE[i*CNT_WIDTH +: CNT_WIDTH];

        if (RUN_CLR[i]) begin
          if (ovf_now[i])
            cnt_q[i] <= load_q[i];
        end else if (RUN_SET[i]) begin
          cnt_q[i] <= WR_LOAD[i] ? LOAD_VALUE[i*CNT_WIDTH +: CNT_WIDTH] : load_q[i];
        end else if (cnt_en[i]) begin
          cnt_q[i] <= ovf_now[i] ? load_q[i] : cnt_q[i] + 1'b1;
        end

        if (RUN_SET[i] && !RUN_CLR[i])
          pre_q[i] <= '0;
        else if (run_q[i] && TICK)
          pre_q[i] <= pre_q[i] + 1'b1;

        if (RUN_CLR[i])
          run_q[i] <= 1'b0;
        else if (RUN_SET[i])
          run_q[i] <= 1'b1;
        else if (ovf_now[i] && !AUTO_RELOAD[i])
          run_q[i] <= 1'b0;

        if (ovf_now[i])
          flag_q[i] <= 1'b1;
        else if (FLAG_CLR[i])
          flag_q[i] <= 1'b0;

        ovf_q[i] <= ovf_now[i];
      end
    end
  end

  always_comb begin
    COUNT = '0;
    for (int unsigned i = 0; i < N_TIMERS; i++)
      COUNT[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
  end

  assign FLAG    = flag_q;
  assign OVF     = ovf_q;
  assign RUNNING = run_q;
  assign nIRQ    = ~|(flag_q & IRQ_EN);

endmodule

// File: tb/tb_ym_timer_bank.sv
// Directed bench for ym_timer_bank: a cycle-by-cycle vector table on channel 0
// followed by multi-cycle sequences for prescaling, one-shot and reset.
module tb_ym_timer_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic [19:0] load_value;
  logic [1:0]  wr_load, run_set, run_clr, flag_clr, irq_en, auto_reload, prescale_sel;
  logic [1:0]  flag, ovf, running;
  logic [19:0] count;
  logic        n_irq;

  int n_tests = 0;
  int n_fail  = 0;

  ym_timer_bank #(.N_TIMERS(2), .CNT_WIDTH(10), .PRE_DIV(16)) dut (
    .CLK(clk), .RESET(rst), .TICK(tick), .LOAD_VALUE(load_value),
    .WR_LOAD(wr_load), .RUN_SET(run_set), .RUN_CLR(run_clr), .FLAG_CLR(flag_clr),
    .IRQ_EN(irq_en), .AUTO_RELOAD(auto_reload), .PRESCALE_SEL(prescale_sel),
    .FLAG(flag), .OVF(ovf), .RUNNING(running), .COUNT(count), .nIRQ(n_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rst, tick;
    logic [1:0] wr, rs, rc, fc, ien, ar, ps;
    logic [9:0] lv0, lv1;
    logic [1:0] e_flag, e_ovf, e_run;
    logic [9:0] e_c0, e_c1;
    logic       e_nirq;
  } vec_t;

  vec_t tbl[$];
  vec_t v;

  // Next record: levels and expected state carry over, strobes and OVF clear.
  function automatic vec_t nv(vec_t p);
    vec_t r = p;
    r.rst = 0; r.tick = 0; r.wr = 0; r.rs = 0; r.rc = 0; r.fc = 0;
    r.e_ovf = 0;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; tick = 0; wr_load = 0; run_set = 0; run_clr = 0; flag_clr = 0;
  endtask

  initial begin
    idle();
    load_value = '0; irq_en = 0; auto_reload = 0; prescale_sel = 0;

    // ---- vector table (channel 0 behaviour, channel 1 idle) ----
    v = '{default: '0};
    v.rst = 1; v.e_nirq = 1;                                    tbl.push_back(v); // 0 reset
    v = nv(v); v.wr = 1; v.lv0 = 1020;                          tbl.push_back(v); // 1
    v = nv(v); v.rs = 1; v.ar = 1; v.ien = 1; v.e_run = 1; v.e_c0 = 1020; tbl.push_back(v); // 2
    v = nv(v); v.tick = 1; v.e_c0 = 1021;                       tbl.push_back(v); // 3
    v = nv(v); v.tick = 1; v.e_c0 = 1022;                       tbl.push_back(v); // 4
    v = nv(v); v.tick = 1; v.e_c0 = 1023;                       tbl.push_back(v); // 5
    v = nv(v); v.tick = 1; v.e_c0 = 1020; v.e_ovf = 1; v.e_flag = 1; v.e_nirq = 0; tbl.push_back(v); // 6
    v = nv(v);                                                  tbl.push_back(v); // 7
    v = nv(v); v.tick = 1; v.e_c0 = 1021;                       tbl.push_back(v); // 8
    v = nv(v); v.tick = 1; v.e_c0 = 1022;                       tbl.push_back(v); // 9
    v = nv(v); v.tick = 1; v.e_c0 = 1023;                       tbl.push_back(v); // 10
    v = nv(v); v.tick = 1; v.fc = 1; v.e_c0 = 1020; v.e_ovf = 1; tbl.push_back(v); // 11 set beats clear
    v = nv(v); v.fc = 1; v.e_flag = 0; v.e_nirq = 1;            tbl.push_back(v); // 12 lone clear
    v = nv(v); v.tick = 1; v.e_c0 = 1021;                       tbl.push_back(v); // 13
    v = nv(v); v.tick = 1; v.e_c0 = 1022;                       tbl.push_back(v); // 14
    v = nv(v); v.tick = 1; v.e_c0 = 1023;                       tbl.push_back(v); // 15
    v = nv(v); v.tick = 1; v.ien = 0; v.e_c0 = 1020; v.e_ovf = 1; v.e_flag = 1; v.e_nirq = 1; tbl.push_back(v); // 16 masked
    v = nv(v); v.ien = 1; v.e_nirq = 0;                         tbl.push_back(v); // 17 unmasked
    v = nv(v); v.rc = 1; v.e_run = 0;                           tbl.push_back(v); // 18 stop
    v = nv(v); v.tick = 1;                                      tbl.push_back(v); // 19 stopped: no count
    v = nv(v); v.wr = 1; v.lv0 = 5;                             tbl.push_back(v); // 20
    v = nv(v); v.rs = 1; v.rc = 1;                              tbl.push_back(v); // 21 clr wins, no reload
    v = nv(v); v.rs = 1; v.wr = 1; v.lv0 = 1023; v.ar = 0; v.fc = 1;
               v.e_run = 1; v.e_c0 = 1023; v.e_flag = 0; v.e_nirq = 1; tbl.push_back(v); // 22 set+write
    v = nv(v); v.tick = 1; v.e_ovf = 1; v.e_flag = 1; v.e_run = 0; v.e_nirq = 0; tbl.push_back(v); // 23 one-shot
    v = nv(v); v.tick = 1;                                      tbl.push_back(v); // 24
    v = nv(v); v.rs = 1; v.ar = 1; v.fc = 1; v.e_run = 1; v.e_flag = 0; v.e_nirq = 1; tbl.push_back(v); // 25
    v = nv(v); v.tick = 1; v.rc = 1; v.e_ovf = 1; v.e_flag = 1; v.e_run = 0; v.e_nirq = 0; tbl.push_back(v); // 26 clr + ovf
    v = nv(v);                                                  tbl.push_back(v); // 27
    v = nv(v); v.rs = 1; v.e_run = 1;                           tbl.push_back(v); // 28
    v = nv(v); v.tick = 1; v.wr = 1; v.lv0 = 1021; v.e_ovf = 1; tbl.push_back(v); // 29 old load used
    v = nv(v); v.tick = 1; v.e_ovf = 1; v.e_c0 = 1021;          tbl.push_back(v); // 30 new load picked up
    v = nv(v); v.tick = 1; v.e_c0 = 1022;                       tbl.push_back(v); // 31

    foreach (tbl[k]) begin
      rst = tbl[k].rst; tick = tbl[k].tick;
      wr_load = tbl[k].wr; run_set = tbl[k].rs; run_clr = tbl[k].rc; flag_clr = tbl[k].fc;
      irq_en = tbl[k].ien; auto_reload = tbl[k].ar; prescale_sel = tbl[k].ps;
      load_value = {tbl[k].lv1, tbl[k].lv0};
      step();
      chk($sformatf("vec%0d flag", k),    32'(flag),         32'(tbl[k].e_flag));
      chk($sformatf("vec%0d ovf", k),     32'(ovf),          32'(tbl[k].e_ovf));
      chk($sformatf("vec%0d running", k), 32'(running),      32'(tbl[k].e_run));
      chk($sformatf("vec%0d count0", k),  32'(count[9:0]),   32'(tbl[k].e_c0));
      chk($sformatf("vec%0d count1", k),  32'(count[19:10]), 32'(tbl[k].e_c1));
      chk($sformatf("vec%0d nirq", k),    32'(n_irq),        32'(tbl[k].e_nirq));
    end

    // ---- prescaled channel 1 alongside unprescaled channel 0 ----
    idle(); rst = 1; step();
    idle(); wr_load = 2'b11; load_value = {10'd1022, 10'd1020}; step();
    idle(); run_set = 2'b11; auto_reload = 2'b11; prescale_sel = 2'b10; irq_en = 2'b11; step();
    idle();
    chk("pre start running", 32'(running), 32'd3);
    chk("pre start count1", 32'(count[19:10]), 32'd1022);
    for (int k = 1; k <= 32; k++) begin
      tick = 1; step();
      chk($sformatf("pre tick%0d ovf0", k), 32'(ovf[0]), 32'(k % 4 == 0));
      chk($sformatf("pre tick%0d ovf1", k), 32'(ovf[1]), 32'(k == 32));
      if (k == 15) chk("pre count1 before first enable", 32'(count[19:10]), 32'd1022);
      if (k == 16) chk("pre count1 after first enable", 32'(count[19:10]), 32'd1023);
    end
    chk("pre end count0", 32'(count[9:0]), 32'd1020);
    chk("pre end count1", 32'(count[19:10]), 32'd1022);
    chk("pre end flag", 32'(flag), 32'd3);
    chk("pre end nirq", 32'(n_irq), 32'd0);

    // ---- reset landing on an overflow, with every strobe asserted ----
    for (int k = 0; k < 3; k++) begin tick = 1; step(); end
    chk("rst pre count0", 32'(count[9:0]), 32'd1023);
    rst = 1; tick = 1; wr_load = 2'b11; run_set = 2'b11; flag_clr = 2'b11;
    load_value = '1; step();
    idle();
    chk("rst flag", 32'(flag), 32'd0);
    chk("rst ovf", 32'(ovf), 32'd0);
    chk("rst running", 32'(running), 32'd0);
    chk("rst count", 32'(count), 32'd0);
    chk("rst nirq", 32'(n_irq), 32'd1);
    for (int k = 0; k < 20; k++) begin
      tick = 1; step();
      chk($sformatf("post-rst %0d ovf", k), 32'(ovf), 32'd0);
      chk($sformatf("post-rst %0d count", k), 32'(count), 32'd0);
      chk($sformatf("post-rst %0d running", k), 32'(running), 32'd0);
    end

    // ---- one-shot with load of all ones: single overflow then silence ----
    idle(); rst = 1; step();
    idle(); wr_load = 2'b01; load_value = {10'd0, 10'd1023}; step();
    idle(); run_set = 2'b01; auto_reload = 2'b00; prescale_sel = 2'b00; irq_en = 2'b01; step();
    idle();
    begin
      int pulses = 0;
      for (int k = 1; k <= 101; k++) begin
        tick = 1; step();
        if (ovf[0]) pulses++;
        chk($sformatf("oneshot tick%0d ovf0", k), 32'(ovf[0]), 32'(k == 1));
        chk($sformatf("oneshot tick%0d running0", k), 32'(running[0]), 32'd0);
      end
      chk("oneshot pulse total", 32'(pulses), 32'd1);
    end
    chk("oneshot count0", 32'(count[9:0]), 32'd1023);
    chk("oneshot flag", 32'(flag), 32'd1);
    chk("oneshot nirq", 32'(n_irq), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ym_timer_bank.md
YM_TIMER_BANK -- requirements
Module: ym_timer_bank

Interface
REQ-001 SHALL have parameter N_TIMERS, default 2, giving the number of independent timer channels (1..8).
REQ-002 SHALL have parameter CNT_WIDTH, default 10, giving the counter and load width of every channel (2..16).
REQ-003 SHALL have parameter PRE_DIV, default 16, giving the prescaled tick divisor (power of two, 2..256).
REQ-004 SHALL have port CLK  in  1  system clock; one clock only, all logic on the rising edge.
REQ-005 SHALL have port RESET  in  1  synchronous, active-high reset.
REQ-006 SHALL have port TICK  in  1  base count enable, one-CLK pulse (the 144-clock tick).
REQ-007 SHALL have port LOAD_VALUE  in  N_TIMERS*CNT_WIDTH  per-channel load data; channel i occupies bits [i*CNT_WIDTH +: CNT_WIDTH].
REQ-008 SHALL have port WR_LOAD  in  N_TIMERS  per-channel strobe that writes LOAD_VALUE into the load register.
REQ-009 SHALL have ports RUN_SET / RUN_CLR  in  N_TIMERS  per-channel start / stop strobes.
REQ-010 SHALL have port FLAG_CLR  in  N_TIMERS  per-channel overflow flag clear strobe.
REQ-011 SHALL have port IRQ_EN  in  N_TIMERS  per-channel interrupt enable level.
REQ-012 SHALL have port AUTO_RELOAD  in  N_TIMERS  per-channel mode level: 1 = periodic, 0 = one-shot.
REQ-013 SHALL have port PRESCALE_SEL  in  N_TIMERS  per-channel level: 0 = count on every TICK, 1 = count on every PRE_DIV-th TICK.
REQ-014 SHALL have port FLAG  out  N_TIMERS  sticky per-channel overflow flags.
REQ-015 SHALL have port OVF  out  N_TIMERS  per-channel overflow pulses, one CLK wide.
REQ-016 SHALL have port RUNNING  out  N_TIMERS  per-channel run state.
REQ-017 SHALL have port COUNT  out  N_TIMERS*CNT_WIDTH  per-channel live counter values.
REQ-018 SHALL have port nIRQ  out  1  active-low interrupt request.

Function
REQ-019 Each channel SHALL hold a load register, a counter, a prescaler of log2(PRE_DIV) bits, a run bit and a flag bit.
REQ-020 WR_LOAD[i] SHALL update only the load register on the next edge; a running counter SHALL keep counting and SHALL pick up the new value at its next reload.
REQ-021 RUN_SET[i] SHALL, on the next edge, load the counter from the load register, clear the prescaler and set RUNNING[i]. If WR_LOAD[i] is also asserted in the same cycle, the counter SHALL take the new LOAD_VALUE.
REQ-022 RUN_CLR[i] SHALL clear RUNNING[i] on the next edge while the counter holds its value; if RUN_SET[i] and RUN_CLR[i] are asserted together, RUN_CLR SHALL win and the counter SHALL not be reloaded.
REQ-023 Count enable for channel i SHALL be: RUNNING[i] & TICK & (PRESCALE_SEL[i] == 0 or prescaler == PRE_DIV-1).
REQ-024 The prescaler SHALL advance on every TICK while the channel is running and SHALL wrap from PRE_DIV-1 to 0.
REQ-025 On count enable, the counter SHALL increment by 1, unless it equals 2^CNT_WIDTH-1, in which case the channel overflows.
REQ-026 On overflow, the counter SHALL reload from the load register, OVF[i] SHALL pulse high for exactly the following cycle, and FLAG[i] SHALL set.
REQ-027 The period SHALL be (2^CNT_WIDTH - load) enabled ticks; a load of all ones SHALL overflow on every enabled tick.
REQ-028 In one-shot mode (AUTO_RELOAD[i]=0), the overflow SHALL also clear RUNNING[i]; the counter SHALL still reload.
REQ-029 FLAG_CLR[i] SHALL clear FLAG[i] on the next edge; if an overflow occurs in the same cycle, the set SHALL win and FLAG[i] SHALL remain 1.
REQ-030 A RUN_CLR in the same cycle as an overflow SHALL still produce the OVF pulse and set the flag, and RUNNING SHALL be 0 afterwards.
REQ-031 nIRQ SHALL be combinational: ~|(FLAG & IRQ_EN); deasserting IRQ_EN SHALL mask the interrupt without clearing FLAG.
REQ-032 Channels SHALL be fully independent; simultaneous events on different channels SHALL not interact.

Reset
REQ-033 While RESET=1, all load registers, counters, prescalers, RUNNING, FLAG and OVF SHALL be 0 on the next edge, and nIRQ SHALL be 1.
REQ-034 RESET SHALL override every strobe in the same cycle, including in the middle of a count; no OVF pulse SHALL follow a reset.

Verification
REQ-035 Channel 0: load=1020, PRESCALE_SEL=0, AUTO_RELOAD=1, IRQ_EN=1, RUN_SET, TICK every cycle -> OVF[0] pulses after 4 ticks and then every 4 ticks; COUNT0 returns to 1020; FLAG[0]=1; nIRQ=0.
REQ-036 Channel 1: load=1022, PRESCALE_SEL=1, TICK every cycle -> first OVF[1] after 32 ticks; channel 0 is unaffected.
REQ-037 Channel 0: one-shot, load=1023 -> exactly one OVF[0] on the first enabled tick; RUNNING[0]=0 afterwards; no further OVF over 100 ticks.
REQ-038 FLAG_CLR[0] in the same cycle as an overflow -> FLAG[0] stays 1; a lone FLAG_CLR[0] -> FLAG[0]=0 and nIRQ=1.
REQ-039 RESET pulsed while both channels are mid-count -> all outputs are 0 and nIRQ=1 on the next edge; no counting resumes until RUN_SET.
REQ-040 RUN_SET[0] and RUN_CLR[0] together on a stopped channel -> RUNNING[0] stays 0 and COUNT0 is unchanged.
